mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Data-memory access stage for the pipelined core. Takes load/store ops from the
//  execute stage, runs a req/ack handshake to data memory, aligns byte/half/word
//  data, and returns a stall request to the pipeline controller.
//  It supplies the memory read/write stall that feeds back into the stage enables.
// PARAMETERS
//  ADDR_W   32  memory address width
//  TIMEOUT  15  max cycles waiting for mem_ack (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1       core clock; single clock domain
//  rst          in   1       synchronous, active-high reset
//  en           in   1       stage enable from pipeline control; op sampled only when 1
//  ld           in   1       load request (from op_data)
//  st           in   1       store request (from op_data)
//  func3        in   3       RV32 width/sign code
//  addr         in   ADDR_W  byte address
//  wdata        in   32      store data, right-aligned
//  rd_in        in   5       load destination register
//  stall_req    out  1       freeze fetch/stage1/stage2 while access in flight
//  wb_valid     out  1       1-cycle pulse: load_data/rd_out valid
//  load_data    out  32      aligned, sign/zero-extended load result
//  rd_out       out  5       destination register for load_data
//  access_err   out  1       1-cycle pulse: misaligned address or illegal func3
//  mem_req      out  1       memory request, held until acked
//  mem_we       out  1       1 = write
//  mem_addr     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  mem_be       out  4       byte enables
//  mem_wdata    out  32      lane-replicated store data
//  mem_rdata    in   32      read data, valid with mem_ack
//  mem_ack      in   1       completion strobe
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (stall_req, wb_valid, access_err, mem_req, mem_we,
//    mem_be, mem_addr, mem_wdata, load_data, rd_out).
//  - FSM IDLE -> REQ -> DONE -> IDLE. DONE accepts new requests exactly like IDLE.
//  - Accept at cycle T when state is IDLE/DONE, en=1, (ld|st)=1, op legal. ld has
//    priority if ld and st are both set. addr, wdata, func3, rd_in are latched at T.
//  - stall_req is combinational: 1 in the accept cycle T and in every REQ cycle;
//    0 in IDLE/DONE when not accepting.
//  - mem_req and mem_we/addr/be/wdata are registered: valid from T+1, held stable until
//    the cycle mem_ack=1. mem_req drops the next cycle. mem_ack in IDLE/DONE is ignored.
//  - On ack at cycle A: state DONE at A+1; for loads wb_valid=1 at A+1 with load_data and
//    rd_out. load_data holds its value until the next load completes.
//  - Legal func3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH,
//    010 SW. Alignment: H needs addr[0]=0; W needs addr[1:0]=0.
//  - Illegal or misaligned op: no memory access, stall_req stays 0, state unchanged,
//    access_err pulses at T+1.
//  - Byte enables: B -> 1<<addr[1:0]; H -> addr[1] ? 1100 : 0011; W -> 1111.
//  - Store data: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
//  - Load extract: take the lane selected by addr[1:0]; LB/LH sign-extend; LBU/LHU
//    zero-extend.
//  - Synchronous rst mid-access: state IDLE and mem_req=0 after the next edge; a pending
//    wb_valid is discarded.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a 4-bit counter runs in REQ. If no ack arrives after TIMEOUT
//    REQ cycles, drop mem_req, go to DONE, pulse access_err, and suppress wb_valid.
//    A late mem_ack is then ignored.
//  MEM_TIMEOUT_EN undefined: no counter. REQ waits for mem_ack indefinitely.
// TESTING
//  1 LW addr=0x100, ack 3 cycles after mem_req, rdata=0xDEADBEEF, rd_in=5 -> mem_req 3
//    cycles, mem_be=1111, stall 4 cycles, wb_valid 1 cycle with 0xDEADBEEF and rd_out=5.
//  2 LB addr=0x103, rdata=0x80000000 -> load_data=0xFFFFFF80; repeat as LBU -> 0x00000080.
//  3 SH addr=0x102, wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD,
//    mem_addr=0x100, no wb_valid.
//  4 LW addr=0x101, or func3=011 -> access_err pulse at T+1, mem_req and stall_req never 1.
//  5 rst=1 while in REQ -> mem_req=0, stall_req=0 after the edge; a late ack gives no wb_valid.
//  6 MEM_TIMEOUT_EN, TIMEOUT=4, ack never arrives -> mem_req high 4 cycles, then access_err
//    pulse and stall_req released.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory load/store stage with req/ack handshake, lane alignment and pipeline stall
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic              st,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_in,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [31:0]       load_data,
  output logic [4:0]        rd_out,
  output logic              access_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      r_state;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_ld;
`ifdef MEM_TIMEOUT_EN
  logic [3:0]  r_cnt;
`endif
  logic        w_free, w_op, w_legal_f3, w_aligned, w_accept, w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_free     = (r_state != REQ) & ~rst;
    w_op       = w_free & en & (ld | st);
    w_legal_f3 = ld ? (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                    : (func3 inside {3'b000, 3'b001, 3'b010});
    w_aligned  = func3[1:0] == 2'b01 ? ~addr[0] : func3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1;
    w_accept   = w_op & w_legal_f3 & w_aligned;
    w_err      = w_op & ~(w_legal_f3 & w_aligned);
    stall_req  = w_accept | (r_state == REQ);
    w_be       = func3[1] ? 4'b1111 : func3[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    w_wdata    = func3[1] ? wdata : func3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    w_byte     = r_lane[1] ? (r_lane[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                           : (r_lane[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
    w_half     = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load     = r_f3[1] ? mem_rdata
               : r_f3[0] ? {{16{~r_f3[2] & w_half[15]}}, w_half}
                         : {{24{~r_f3[2] & w_byte[7]}}, w_byte};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_f3       <= '0;
      r_lane     <= '0;
      r_rd       <= '0;
      r_ld       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt      <= '0;
`endif
      wb_valid   <= 1'b0;
      load_data  <= '0;
      rd_out     <= '0;
      access_err <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      wb_valid   <= 1'b0;
      access_err <= w_err;
      if (w_accept) begin
        r_state   <= REQ;
        r_f3      <= func3;
        r_lane    <= addr[1:0];
        r_rd      <= rd_in;
        r_ld      <= ld;
`ifdef MEM_TIMEOUT_EN
        r_cnt     <= '0;
`endif
        mem_req   <= 1'b1;
        mem_we    <= ~ld;
        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_be    <= w_be;
        mem_wdata <= w_wdata;
      end else if (r_state == REQ && mem_ack) begin
        r_state  <= DONE;
        mem_req  <= 1'b0;
        wb_valid <= r_ld;
        if (r_ld) begin
          load_data <= w_load;
          rd_out    <= r_rd;
        end
`ifdef MEM_TIMEOUT_EN
      end else if (r_state == REQ && r_cnt == 4'(TIMEOUT - 1)) begin
        r_state    <= DONE;
        mem_req    <= 1'b0;
        access_err <= 1'b1;
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + 4'd1;
`endif
      end
    end
  end
endmodule
